// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester.
package apb_pkg;

    // Transfer phases of the requester: waiting for a command, APB SETUP,
    // APB ACCESS (possibly with wait states), and holding the response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Registers are word-wide, so the byte-lane bits of PADDR are always zero.
    localparam int APB_ADDR_LSB = 2;

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of the requester, bundled together.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    // The requester's view: it consumes commands and APB replies,
    // and produces responses and the APB request.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    // The opposite side: command/response user plus the APB completer.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_master.sv
// APB3 requester: one command in, one SETUP/ACCESS transfer out, one response
// back. Handles PREADY wait states, PSLVERR and a bounded wait-state timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          PCLK,
    input logic          PRESET,
    apb_master_if.master bus
);

    // A zero timeout disables the counter, but it still needs one bit to exist.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    apb_state_e            state;
    apb_state_e            next_state;

    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [CNT_W-1:0]      wait_cnt;

    logic                  timeout_hit;
    logic                  unused_addr_lsb;

    // The byte-lane bits of the command address are dropped on purpose.
    assign unused_addr_lsb = ^bus.cmd_addr[APB_ADDR_LSB-1:0];

    // Last tolerated ACCESS cycle without PREADY; PREADY still wins if it arrives here.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

    // State register; reset abandons any transfer or pending response at once.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Phase sequencing IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.cmd_valid) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (bus.PREADY || timeout_hit) next_state = RESP;
            RESP:    if (bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered APB request, response capture and wait-state counter.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        pwrite_q  <= bus.cmd_write;
                        paddr_q   <= {bus.cmd_addr[ADDR_WIDTH-1:APB_ADDR_LSB], {APB_ADDR_LSB{1'b0}}};
                        pwdata_q  <= bus.cmd_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_cnt  <= '0;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
                        rsp_err_q   <= bus.PSLVERR;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end else if (timeout_hit) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master with an 8x32 register responder.
module tb_apb_master;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic PCLK;
    logic PRESET;

    apb_master_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    apb_master #(
        .ADDR_WIDTH    (5),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    int          check_count = 0;
    int          fail_count  = 0;
    exp_t        exp_q[$];

    logic [31:0] mem [8] = '{default: 32'h0};
    int          wait_cycles = 0;
    logic        stuck       = 1'b0;
    logic        err_inject  = 1'b0;
    int          acc_cnt     = 0;
    int          acc_len     = 0;
    logic [4:0]  paddr_first = '0;
    logic        pwrite_first = 1'b0;
    logic        prev_setup  = 1'b0;

    int          lat        = 0;
    logic        in_flight  = 1'b0;
    logic        rsp_seen   = 1'b0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Register responder: PREADY held low for wait_cycles ACCESS cycles (or forever when stuck).
    always @(negedge PCLK) begin
        if (bus.PSEL && bus.PENABLE) begin
            acc_cnt = acc_cnt + 1;
            acc_len = acc_cnt;
            if (acc_cnt == 1) begin
                paddr_first  = bus.PADDR;
                pwrite_first = bus.PWRITE;
                checkOutput("setup_phase", 32'(prev_setup), 32'd1);
                checkOutput("paddr_lsb", 32'(bus.PADDR[1:0]), 32'd0);
            end else begin
                checkOutput("paddr_stable", 32'(bus.PADDR), 32'(paddr_first));
                checkOutput("pwrite_stable", 32'(bus.PWRITE), 32'(pwrite_first));
            end
            if (!stuck && acc_cnt > wait_cycles) begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = err_inject;
                bus.PRDATA  = bus.PWRITE ? 32'hDEAD_BEEF : mem[bus.PADDR[4:2]];
                if (bus.PWRITE && !err_inject) mem[bus.PADDR[4:2]] = bus.PWDATA;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                bus.PRDATA  = 32'hDEAD_BEEF;
            end
        end else begin
            acc_cnt     = 0;
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = 32'hDEAD_BEEF;
        end
        prev_setup = bus.PSEL && !bus.PENABLE;
    end

    // Scoreboard monitor: latency on first rsp_valid, data/err on handshake.
    always @(negedge PCLK) begin
        exp_t e;
        if (PRESET) begin
            in_flight = 1'b0;
            rsp_seen  = 1'b0;
        end else begin
            if (in_flight && !rsp_seen) lat = lat + 1;
            if (bus.cmd_valid && bus.cmd_ready) begin
                in_flight = 1'b1;
                rsp_seen  = 1'b0;
                lat       = 0;
            end
            if (bus.rsp_valid && !rsp_seen) begin
                rsp_seen = 1'b1;
                checkOutput("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    checkOutput("latency", 32'(lat), 32'(e.lat));
                    checkOutput("access_cycles", 32'(acc_len), 32'(e.acc));
                    checkOutput("psel_after", 32'(bus.PSEL), 32'd0);
                    checkOutput("penable_after", 32'(bus.PENABLE), 32'd0);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
                checkOutput("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                in_flight = 1'b0;
                rsp_seen  = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input int exp_lat, input int exp_acc);
        exp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.acc   = exp_acc;
        @(posedge PCLK);
        #1;
        exp_q.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            if (bus.cmd_ready) break;
        end
        checkOutput("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge PCLK);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge PCLK);
        end
        checkOutput("rsp_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        PRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(posedge PCLK);
        #1;
        checkOutput("reset_psel", 32'(bus.PSEL), 32'd0);
        checkOutput("reset_penable", 32'(bus.PENABLE), 32'd0);
        checkOutput("reset_pwrite", 32'(bus.PWRITE), 32'd0);
        checkOutput("reset_paddr", 32'(bus.PADDR), 32'd0);
        checkOutput("reset_pwdata", bus.PWDATA, 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        PRESET = 1'b0;

        // zero-wait write then read back
        applyStimulus(1'b1, 5'h04, 32'hA5A5_0001, 32'h0, 1'b0, 3, 1);
        waitDone();
        applyStimulus(1'b0, 5'h04, 32'h0, 32'hA5A5_0001, 1'b0, 3, 1);
        waitDone();

        // unaligned byte address maps onto its word; untouched top register reads zero
        applyStimulus(1'b1, 5'h0B, 32'h0BAD_F00D, 32'h0, 1'b0, 3, 1);
        waitDone();
        applyStimulus(1'b0, 5'h08, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 1);
        waitDone();
        applyStimulus(1'b0, 5'h1C, 32'h0, 32'h0, 1'b0, 3, 1);
        waitDone();

        // three wait states
        applyStimulus(1'b1, 5'h10, 32'h1234_5678, 32'h0, 1'b0, 3, 1);
        waitDone();
        wait_cycles = 3;
        applyStimulus(1'b0, 5'h10, 32'h0, 32'h1234_5678, 1'b0, 6, 4);
        waitDone();
        wait_cycles = 0;

        // PREADY never comes: abort after 16 ACCESS cycles
        stuck = 1'b1;
        applyStimulus(1'b0, 5'h14, 32'h0, 32'h0, 1'b1, 18, 16);
        waitDone();
        stuck = 1'b0;

        // slave error with response back-pressure
        err_inject    = 1'b1;
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b1, 5'h0C, 32'hFFFF_FFFF, 32'h0, 1'b1, 3, 1);
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid) break;
            @(negedge PCLK);
        end
        checkOutput("bp_rsp_arrived", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("bp_rsp_err", 32'(bus.rsp_err), 32'd1);
            checkOutput("bp_rsp_rdata", bus.rsp_rdata, 32'd0);
            checkOutput("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        @(posedge PCLK);
        #1;
        err_inject    = 1'b0;
        bus.rsp_ready = 1'b1;
        waitDone();

        // reset in the middle of ACCESS discards the transfer
        stuck = 1'b1;
        applyStimulus(1'b0, 5'h04, 32'h0, 32'h0, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (acc_cnt >= 3) break;
            @(negedge PCLK);
        end
        checkOutput("mid_access_reached", 32'(acc_cnt >= 3), 32'd1);
        @(negedge PCLK);
        #2;
        PRESET = 1'b1;
        #1;
        checkOutput("arst_psel", 32'(bus.PSEL), 32'd0);
        checkOutput("arst_penable", 32'(bus.PENABLE), 32'd0);
        checkOutput("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge PCLK);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        exp_q.delete();
        stuck = 1'b0;
        applyStimulus(1'b0, 5'h04, 32'h0, 32'hA5A5_0001, 1'b0, 3, 1);
        waitDone();

        repeat (3) @(posedge PCLK);
        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
